// File: rtl/fft_host_link.sv
// Host-side link for the FFT bridge: fetch N samples from source memory, stream
// them out on AR, collect N results from AW into result memory, with watchdog.
module fft_host_link #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic [11:0]           i_samples_number,
  output logic                  o_src_read,
  output logic [11:0]           o_src_index,
  input  logic [DATA_WIDTH-1:0] i_src_data,
  output logic                  o_ARVALID,
  output logic [DATA_WIDTH-1:0] o_ARDATA,
  input  logic                  i_ARREADY,
  input  logic                  i_AWVALID,
  input  logic [DATA_WIDTH-1:0] i_AWDATA,
  output logic                  o_AWREADY,
  output logic                  o_dst_write,
  output logic [11:0]           o_dst_index,
  output logic [DATA_WIDTH-1:0] o_dst_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [2:0]            o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SEND  = 3'd2,
    S_RECV  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_next;
  logic [11:0]           r_n, r_tx_cnt, r_rx_cnt;
  logic [15:0]           r_wdog;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_loaded;
  logic                  r_error;

  logic w_start_ok, w_start_bad, w_ar_beat, w_aw_beat, w_last_tx, w_last_rx, w_timeout;

  always_comb begin
    w_start_ok  = (r_state == S_IDLE) && i_start && (i_samples_number != 12'd0);
    w_start_bad = (r_state == S_IDLE) && i_start && (i_samples_number == 12'd0);
    w_ar_beat   = (r_state == S_SEND) && r_loaded && i_ARREADY;
    w_aw_beat   = (r_state == S_RECV) && i_AWVALID;
    w_last_tx   = (r_tx_cnt == r_n - 12'd1);
    w_last_rx   = (r_rx_cnt == r_n - 12'd1);
    w_timeout   = (r_state == S_RECV) && !i_AWVALID && (r_wdog == TO_LAST);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_FETCH;
      S_FETCH: w_next = S_SEND;
      S_SEND:  if (w_ar_beat) w_next = w_last_tx ? S_RECV : S_FETCH;
      S_RECV: begin
        if (w_aw_beat && w_last_rx) w_next = S_DONE;
        else if (w_timeout)         w_next = S_IDLE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_src_read  = (r_state == S_FETCH);
    o_src_index = o_src_read ? r_tx_cnt : '0;
    o_ARVALID   = (r_state == S_SEND) && r_loaded;
    o_ARDATA    = o_ARVALID ? r_data : '0;
    o_AWREADY   = (r_state == S_RECV);
    o_dst_write = w_aw_beat;
    o_dst_index = w_aw_beat ? r_rx_cnt : '0;
    o_dst_data  = w_aw_beat ? i_AWDATA : '0;
    o_busy      = (r_state == S_FETCH) || (r_state == S_SEND) || (r_state == S_RECV);
    o_done      = (r_state == S_DONE);
    o_error     = r_error;
    o_state     = r_state;
  end

  // Source data arrives during the first SEND cycle; ARVALID waits one cycle
  // for it to be registered so ARDATA never changes under a stall.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state  <= S_IDLE;
      r_n      <= '0;
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
      r_wdog   <= '0;
      r_data   <= '0;
      r_loaded <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= w_start_bad || w_timeout;
      if (w_start_ok) begin
        r_n      <= i_samples_number;
        r_tx_cnt <= '0;
        r_rx_cnt <= '0;
      end
      if (r_state == S_FETCH) r_loaded <= 1'b0;
      if ((r_state == S_SEND) && !r_loaded) begin
        r_data   <= i_src_data;
        r_loaded <= 1'b1;
      end
      if (w_ar_beat) r_tx_cnt <= r_tx_cnt + 12'd1;
      if (w_aw_beat) r_rx_cnt <= r_rx_cnt + 12'd1;
      if ((w_next == S_RECV) && (r_state != S_RECV)) r_wdog <= '0;
      else if (r_state == S_RECV) r_wdog <= w_aw_beat ? 16'd0 : r_wdog + 16'd1;
    end
  end

endmodule

// File: tb/tb_fft_host_link.sv
// Scoreboard bench for fft_host_link: stimulus pushes expected AR/src/dst
// traffic into queues, a negedge monitor pops and compares.
module tb_fft_host_link;
  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_start = 1'b0;
  logic [11:0] i_samples_number = '0;
  logic        o_src_read;
  logic [11:0] o_src_index;
  logic [31:0] i_src_data = '0;
  logic        o_ARVALID;
  logic [31:0] o_ARDATA;
  logic        i_ARREADY = 1'b0;
  logic        i_AWVALID = 1'b0;
  logic [31:0] i_AWDATA = '0;
  logic        o_AWREADY;
  logic        o_dst_write;
  logic [11:0] o_dst_index;
  logic [31:0] o_dst_data;
  logic        o_busy, o_done, o_error;
  logic [2:0]  o_state;

  fft_host_link #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_samples_number(i_samples_number),
    .o_src_read(o_src_read), .o_src_index(o_src_index), .i_src_data(i_src_data),
    .o_ARVALID(o_ARVALID), .o_ARDATA(o_ARDATA), .i_ARREADY(i_ARREADY),
    .i_AWVALID(i_AWVALID), .i_AWDATA(i_AWDATA), .o_AWREADY(o_AWREADY),
    .o_dst_write(o_dst_write), .o_dst_index(o_dst_index), .o_dst_data(o_dst_data),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] src_mem [16];
  always @(posedge i_clk) if (o_src_read) i_src_data <= src_mem[o_src_index[3:0]];

  logic [31:0] exp_ar[$];
  logic [11:0] exp_src[$];
  logic [11:0] exp_didx[$];
  logic [31:0] exp_ddat[$];
  int n_checks = 0, n_err = 0, n_done = 0, n_errp = 0, n_src = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_ar = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: actual=0x%0h required=no transfer", name, act);
  endtask

  // Monitor
  initial forever begin
    @(negedge i_clk);
    if (!i_rstn) prev_stall = 1'b0;
    else begin
      if (prev_stall) chk("ar_hold", {o_ARVALID, o_ARDATA}, {1'b1, prev_ar});
      if (o_ARVALID && i_ARREADY) begin
        if (exp_ar.size() == 0) unexpected("ar_beat", o_ARDATA);
        else chk("ar_data", o_ARDATA, exp_ar.pop_front());
      end
      prev_stall = o_ARVALID && !i_ARREADY;
      prev_ar    = o_ARDATA;
      if (o_src_read) begin
        n_src++;
        if (exp_src.size() == 0) unexpected("src_read", o_src_index);
        else chk("src_index", o_src_index, exp_src.pop_front());
      end
      if (o_dst_write) begin
        if (exp_didx.size() == 0) unexpected("dst_write", o_dst_data);
        else begin
          chk("dst_index", o_dst_index, exp_didx.pop_front());
          chk("dst_data", o_dst_data, exp_ddat.pop_front());
        end
      end
      if (o_done) begin
        n_done++;
        chk("busy_in_done", o_busy, 0);
      end
      if (o_error) n_errp++;
    end
  end

  task automatic start(input int n);
    i_samples_number = 12'(n);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      src_mem[i] = base + 32'(i);
      exp_ar.push_back(base + 32'(i));
      exp_src.push_back(12'(i));
    end
  endtask

  task automatic wait_arvalid();
    for (int k = 0; k < 50; k++) begin
      if (o_ARVALID) break;
      @(posedge i_clk); #1;
    end
    chk("arvalid_seen", o_ARVALID, 1);
  endtask

  task automatic wait_awready();
    for (int k = 0; k < 200; k++) begin
      if (o_AWREADY) break;
      @(posedge i_clk); #1;
    end
    chk("awready_seen", o_AWREADY, 1);
  endtask

  task automatic drive_aw(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      i_AWVALID = 1'b1;
      i_AWDATA  = base + 32'(i);
      exp_didx.push_back(12'(i));
      exp_ddat.push_back(base + 32'(i));
      @(posedge i_clk); #1;
    end
    i_AWVALID = 1'b0;
    i_AWDATA  = '0;
  endtask

  task automatic finish_txn(input int d0, input int e0, input int done_exp, input int err_exp);
    repeat (4) @(posedge i_clk);
    #1;
    chk("done_pulses", n_done - d0, done_exp);
    chk("error_pulses", n_errp - e0, err_exp);
    chk("end_state", {o_state, o_busy}, 0);
    chk("queues_left", exp_ar.size() + exp_src.size() + exp_didx.size(), 0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {o_busy, o_done, o_error, o_ARVALID, o_AWREADY, o_src_read, o_dst_write, o_state}, 0);
    chk({name, "_buses"}, {o_src_index, o_dst_index, o_ARDATA, o_dst_data} == '0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, seen;
    logic busy_seen;

    repeat (3) @(posedge i_clk);
    #1;
    chk_all_zero("reset_outputs");
    i_rstn = 1'b1;
    @(posedge i_clk); #1;

    // Basic N=4 transaction, ARREADY always high
    d0 = n_done; e0 = n_errp;
    load(4, 32'h100);
    i_ARREADY = 1'b1;
    start(4);
    chk("busy_after_start", o_busy, 1);
    wait_awready();
    drive_aw(4, 32'hA0);
    finish_txn(d0, e0, 1, 0);

    // N=2 with a 5-cycle AR stall on the first sample
    d0 = n_done; e0 = n_errp;
    load(2, 32'h200);
    i_ARREADY = 1'b0;
    start(2);
    wait_arvalid();
    repeat (5) begin @(posedge i_clk); #1; end
    chk("arvalid_held", o_ARVALID, 1);
    i_ARREADY = 1'b1;
    wait_awready();
    drive_aw(2, 32'h2A0);
    finish_txn(d0, e0, 1, 0);

    // N=0 start is rejected
    d0 = n_done; e0 = n_errp; seen = n_src;
    busy_seen = 1'b0;
    start(0);
    repeat (4) begin @(negedge i_clk); busy_seen |= o_busy; end
    chk("n0_busy", busy_seen, 0);
    chk("n0_src_reads", n_src - seen, 0);
    @(posedge i_clk); #1;
    finish_txn(d0, e0, 0, 1);

    // Watchdog: one result then silence
    d0 = n_done; e0 = n_errp;
    load(3, 32'h300);
    start(3);
    wait_awready();
    drive_aw(1, 32'hB0);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (o_error) begin seen = k; break; end
    end
    chk("timeout_latency", seen, 9);
    chk("timeout_state", o_state, 0);
    @(posedge i_clk); #1;
    finish_txn(d0, e0, 0, 1);

    // Reset during RECV after 2 of 4 results, then fresh N=1
    d0 = n_done; e0 = n_errp;
    load(4, 32'h400);
    start(4);
    wait_awready();
    drive_aw(2, 32'hC0);
    i_AWVALID = 1'b1;
    i_AWDATA  = 32'hC2;
    i_rstn    = 1'b0;
    #1;
    chk_all_zero("midreset_outputs");
    i_AWVALID = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    chk("midreset_pulses", (n_done - d0) + (n_errp - e0), 0);
    load(1, 32'h55);
    start(1);
    wait_awready();
    drive_aw(1, 32'hD0);
    finish_txn(d0, e0, 1, 0);

    // i_start with a new N during SEND must be ignored
    d0 = n_done; e0 = n_errp;
    load(3, 32'h600);
    i_ARREADY = 1'b0;
    start(3);
    wait_arvalid();
    i_samples_number = 12'd1;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    i_ARREADY = 1'b1;
    wait_awready();
    drive_aw(3, 32'hE0);
    finish_txn(d0, e0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
